// File: rtl/int_to_float.sv
// Purpose : 32-bit signed integer to IEEE-754 single, round-to-nearest-even.
// Latency : nonzero input stb high 6+L edges after accept (L = leading zeros of |a|); zero input 2 edges.
// Backpressure: one conversion in flight; input_a_ack low while busy, output_z held until output_z_ack.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   input_a/_stb/_ack    integer operand with stb/ack handshake
//   output_z/_stb/_ack   float result with stb/ack handshake
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [2:0] GET_A     = 3'd0;
  localparam logic [2:0] CONVERT_0 = 3'd1;
  localparam logic [2:0] CONVERT_1 = 3'd2;
  localparam logic [2:0] CONVERT_2 = 3'd3;
  localparam logic [2:0] ROUND     = 3'd4;
  localparam logic [2:0] PACK      = 3'd5;
  localparam logic [2:0] PUT_Z     = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] mag_q, mag_d;
  logic [5:0]  exp_q, exp_d;
  logic [23:0] man_q, man_d;
  logic        guard_q, guard_d;
  logic        round_q, round_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic [31:0] z_q, z_d;
  logic        a_ack_q, a_ack_d;
  logic        z_stb_q, z_stb_d;

  assign input_a_ack  = a_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    man_d    = man_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    z_d      = z_q;
    a_ack_d  = a_ack_q;
    z_stb_d  = z_stb_q;

    case (state_q)
      GET_A: begin
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = CONVERT_0;
        end else begin
          a_ack_d = 1'b1;
        end
      end

      CONVERT_0: begin
        if (a_q == 32'h0) begin
          z_d     = 32'h0;
          state_d = PUT_Z;
        end else begin
          sign_d  = a_q[31];
          // Two's-complement negate; 0x80000000 wraps onto itself, which is
          // exactly its magnitude as an unsigned value.
          mag_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
          exp_d   = 6'd31;
          state_d = CONVERT_1;
        end
      end

      CONVERT_1: begin
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 6'd1;
        end else begin
          state_d = CONVERT_2;
        end
      end

      CONVERT_2: begin
        man_d    = mag_q[31:8];
        guard_d  = mag_q[7];
        round_d  = mag_q[6];
        sticky_d = |mag_q[5:0];
        state_d  = ROUND;
      end

      ROUND: begin
        if (guard_q && (round_q || sticky_q || man_q[0])) begin
          man_d = man_q + 24'd1;
          // All-ones mantissa wraps to 1.000.. at the next binade.
          if (man_q == 24'hFFFFFF) begin
            exp_d = exp_q + 6'd1;
          end
        end
        state_d = PACK;
      end

      PACK: begin
        z_d     = {sign_q, {2'b00, exp_q} + 8'd127, man_q[22:0]};
        state_d = PUT_Z;
      end

      PUT_Z: begin
        if (!z_stb_q) begin
          z_stb_d = 1'b1;
        end else if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end

      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GET_A;
      a_q      <= 32'h0;
      mag_q    <= 32'h0;
      exp_q    <= 6'h0;
      man_q    <= 24'h0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      z_q      <= 32'h0;
      a_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      z_q      <= z_d;
      a_ack_q  <= a_ack_d;
      z_stb_q  <= z_stb_d;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Purpose : self-checking bench for int_to_float (directed vectors, arithmetic reference model).
// Latency : checks result and stb latency of every conversion against the model.
// Backpressure: exercises held output_z_ack, busy-time input stb, and mid-conversion reset.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'h0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] v;
    int          t;
  } xfer_t;
  xfer_t xq[$];

  logic        prev_stb = 1'b0;
  logic [31:0] held_z   = 32'h0;

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Position of the most significant set bit of |a| (a != 0).
  function automatic int msb_of(input logic [31:0] a);
    longint ua, m;
    int p;
    ua = longint'({32'h0, a});
    m  = a[31] ? (64'sh1_0000_0000 - ua) : ua;
    p  = 0;
    for (int i = 0; i < 33; i++) if (m >= (64'sd1 <<< i)) p = i;
    return p;
  endfunction

  // Reference: exact integer magnitude, divide down to 24 significant bits,
  // round the discarded remainder to nearest/even.
  function automatic logic [31:0] model(input logic [31:0] a);
    longint ua, m, q, rem, half;
    int p, sh;
    logic [7:0] e;
    if (a == 32'h0) return 32'h0;
    ua = longint'({32'h0, a});
    m  = a[31] ? (64'sh1_0000_0000 - ua) : ua;
    p  = msb_of(a);
    if (p <= 23) begin
      q = m <<< (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >>> sh;
      rem  = m - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        p = p + 1;
      end
    end
    e = 8'(p + 127);
    return {a[31], e, q[22:0]};
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    if (a == 32'h0) return 2;
    return 6 + (31 - msb_of(a));
  endfunction

  // Compare process: every cycle the result is valid.
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
    end else begin
      if (output_z_stb) begin
        if (!prev_stb) begin
          if (xq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_stb: got result %h with no accepted input", output_z);
          end else begin
            xfer_t x;
            x = xq.pop_front();
            chk($sformatf("model_z(%h)", x.v), output_z, model(x.v));
            chk($sformatf("model_lat(%h)", x.v), 32'(cyc - x.t), 32'(lat_of(x.v)));
          end
          held_z = output_z;
        end else begin
          chk("z_stable", output_z, held_z);
        end
        chk("ack_low_while_busy", {31'h0, input_a_ack}, 32'h0);
      end
      prev_stb = output_z_stb;
    end
  end

  // Wait (at negedges) for input_a_ack with input_a_stb up; returns transfer edge or -1.
  task automatic send(input logic [31:0] v, output int t);
    int n;
    @(negedge clk);
    input_a     = v;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: input_a_ack never rose for %h", v);
      t = -1;
      input_a_stb = 1'b0;
      return;
    end
    t = cyc + 1;
    @(negedge clk);
    input_a_stb = 1'b0;
    input_a     = 32'hDEAD_BEEF;
  endtask

  task automatic convert(input logic [31:0] v, input bit use_lit, input logic [31:0] lit,
                         input int lat_lit, input int hold);
    int t, n;
    send(v, t);
    if (t < 0) return;
    xq.push_back('{v: v, t: t});
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!output_z_stb) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: output_z_stb never rose for %h", v);
      void'(xq.pop_front());
      return;
    end
    if (use_lit) chk($sformatf("lit_z(%h)", v), output_z, lit);
    if (lat_lit >= 0) chk($sformatf("lit_lat(%h)", v), 32'(cyc - t), 32'(lat_lit));
    if (hold > 0) begin
      // A new operand offered while busy must be ignored.
      input_a     = 32'h0000_0055;
      input_a_stb = 1'b1;
      repeat (hold) @(negedge clk);
      input_a_stb = 1'b0;
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    chk($sformatf("stb_drop(%h)", v), {31'h0, output_z_stb}, 32'h0);
  endtask

  initial begin
    int t;

    // Pin the reference model with hand-computed values.
    chk("pin_model_1",        model(32'h0000_0001), 32'h3F80_0000);
    chk("pin_model_tie_even", model(32'h0100_0001), 32'h4B80_0000);
    chk("pin_model_tie_up",   model(32'h0100_0003), 32'h4B80_0002);
    chk("pin_model_carry",    model(32'h7FFF_FFFF), 32'h4F00_0000);
    chk("pin_model_min",      model(32'h8000_0000), 32'hCF00_0000);

    // Reset state.
    @(negedge clk);
    chk("rst_ack", {31'h0, input_a_ack}, 32'h0);
    chk("rst_stb", {31'h0, output_z_stb}, 32'h0);
    chk("rst_z", output_z, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ack_after_rst", {31'h0, input_a_ack}, 32'h1);

    convert(32'h0000_0001, 1, 32'h3F80_0000, 37, 0);
    convert(32'hFFFF_FFFF, 1, 32'hBF80_0000, -1, 0);
    convert(32'h8000_0000, 1, 32'hCF00_0000, 6, 0);
    convert(32'h0000_0000, 1, 32'h0000_0000, 2, 0);
    convert(32'h0100_0001, 1, 32'h4B80_0000, -1, 0);
    convert(32'h0100_0003, 1, 32'h4B80_0002, -1, 0);
    convert(32'h7FFF_FFFF, 1, 32'h4F00_0000, -1, 0);
    convert(32'h00FF_FFFF, 1, 32'h4B7F_FFFF, -1, 0);
    convert(32'hFFFF_FFFB, 1, 32'hC0A0_0000, -1, 0);
    convert(32'h1234_5678, 0, 32'h0, -1, 0);
    convert(32'h0100_0002, 1, 32'h4B80_0001, -1, 0);

    // Backpressure: result held for 10 cycles.
    convert(32'h0000_0064, 1, 32'h42C8_0000, -1, 10);

    // Reset in the middle of normalisation discards the conversion.
    send(32'h0000_0001, t);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", {31'h0, input_a_ack}, 32'h0);
    chk("midrst_stb", {31'h0, output_z_stb}, 32'h0);
    chk("midrst_z", output_z, 32'h0);
    rst = 1'b0;
    xq.delete();

    convert(32'h0100_0003, 1, 32'h4B80_0002, -1, 0);
    convert(32'h0000_0000, 1, 32'h0000_0000, 2, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
